// File: rtl/anticipator_trainer_pkg.sv
// Shared definitions for the anticipator table trainer: default sizes, index
// field layout, FSM state encoding and the jump opcodes that feed the index.
package anticipator_trainer_pkg;

  localparam int AW_DEF    = 12;
  localparam int DW_DEF    = 2;
  localparam int CNT_W_DEF = 16;
  localparam logic [DW_DEF-1:0] INIT_VAL_DEF = '0;

  // Only the upper opcode nibble takes part in the table index.
  localparam logic [7:0] JUMP_LOOP   = 8'h10;
  localparam logic [7:0] JUMP_COND   = 8'h20;
  localparam logic [7:0] JUMP_UNCOND = 8'h30;
  localparam logic [7:0] JUMP_RET    = 8'h40;

  typedef struct packed {
    logic [3:0] ctx;
    logic [3:0] opc_hi;
    logic [3:0] ctx2;
  } tbl_idx_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [AW_DEF-1:0] make_idx(input logic [3:0] ctx,
                                                 input logic [3:0] opc_hi,
                                                 input logic [3:0] ctx2);
    tbl_idx_t idx;
    idx.ctx    = ctx;
    idx.opc_hi = opc_hi;
    idx.ctx2   = ctx2;
    return idx;
  endfunction

endpackage

// File: rtl/anticipator_trainer_if.sv
// Outcome-event handshake plus the external table RAM ports and status.
interface anticipator_trainer_if
  import anticipator_trainer_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic             upd_valid;
  logic             upd_ready;
  logic [AW-1:0]    upd_addr;
  logic             upd_taken;
  logic [AW-1:0]    rd_addr;
  logic [DW-1:0]    rd_data;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             busy;
  logic [CNT_W-1:0] upd_count;

  modport slave (
    input  upd_valid, upd_addr, upd_taken, rd_data,
    output upd_ready, rd_addr, wr_en, wr_addr, wr_data, busy, upd_count
  );

  modport master (
    output upd_valid, upd_addr, upd_taken, rd_data,
    input  upd_ready, rd_addr, wr_en, wr_addr, wr_data, busy, upd_count
  );
endinterface

// File: rtl/anticipator_satcnt.sv
// Saturating up/down step of a DW-bit confidence counter.
module anticipator_satcnt #(
  parameter int DW = 2
) (
  input  logic [DW-1:0] old_i,
  input  logic          taken_i,
  output logic [DW-1:0] new_o
);
  localparam logic [DW-1:0] CNT_MAX = '1;

  always_comb begin
    new_o = old_i;
    if (taken_i) begin
      if (old_i != CNT_MAX) new_o = old_i + 1'b1;
    end else begin
      if (old_i != '0) new_o = old_i - 1'b1;
    end
  end
endmodule

// File: rtl/anticipator_trainer.sv
// Write side of the anticipator table: init sweep, then one read-modify-write
// counter update per cycle with forwarding from the pending write.
//
// state   | meaning
// INIT    | sweeping every entry to INIT_VAL, no events accepted
// RUN     | accepting outcome events, pending write issued next cycle
module anticipator_trainer
  import anticipator_trainer_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [DW-1:0] INIT_VAL = INIT_VAL_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  anticipator_trainer_if.slave bus
);
  localparam logic [AW-1:0]    IDX_LAST = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic          upd_ready;
  logic          accept;
  logic          fwd_hit;
  logic [DW-1:0] old_val;
  logic [DW-1:0] new_val;

  assign upd_ready = (state_q == ST_RUN) & ~flush_i;
  assign accept    = bus.upd_valid & upd_ready;

  // The write registers double as the pending stage; its data is newer than the RAM.
  assign fwd_hit = wr_en_q & (wr_addr_q == bus.upd_addr);
  assign old_val = fwd_hit ? wr_data_q : bus.rd_data;

  anticipator_satcnt #(.DW(DW)) u_satcnt (
    .old_i   (old_val),
    .taken_i (bus.upd_taken),
    .new_o   (new_val)
  );

  assign bus.upd_ready = upd_ready;
  assign bus.rd_addr   = (state_q == ST_RUN) ? bus.upd_addr : idx_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = (state_q == ST_INIT);
  assign bus.upd_count = cnt_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = '0;
        if (flush_i) begin
          idx_d = '0;
        end else if (wr_en_q && (wr_addr_q == IDX_LAST)) begin
          // Last entry is on the write port this cycle; sweep is complete.
          state_d = ST_RUN;
          idx_d   = '0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = INIT_VAL;
          idx_d     = idx_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          state_d = ST_INIT;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = bus.upd_addr;
          wr_data_d = new_val;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_INIT;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule
